fpu_reg_wb: RTL and testbench
=============================

Name: fpu_reg_wb

Overview:
- FPR writeback and bypass stage directly downstream of the FPU execute unit.
- Consumes the execute unit's result id, value, status and SR.T outputs, and registers them into one E2 pipeline latch.
- Commits E2 to a NUM_FPR x 64 FPR array and supplies three forwarded read ports (Rs, Rt, Rn) back to the execute stage.
- Also owns the post-reset array-clear sequence, the SR.T result register, a fault flag and a retire counter.

Parameters:
NUM_FPR, 64, FPR array depth; ids >= NUM_FPR and id 6'h3F (FPR_ZZR) are never written and always read 0
CLEAR_ON_RESET, 1, 1 = walk-clear the array after reset; 0 = skip straight to RUN, array contents undefined

Ports:
clock  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
exOutId  in  6  FPU result destination id
exOutVal  in  64  FPU result value
exOutOK  in  2  FPU status: READY=0, OK=1, HOLD=2, FAULT=3
exOutSrT  in  1  FPU SR.T result
exHold  in  1  global pipeline stall
exFlush  in  1  kill current EX result (branch flush)
rdIdRs/rdIdRt/rdIdRn  in  6 each  read ids
rdValRs/rdValRt/rdValRn  out  64 each  forwarded read data, combinational
outSrT  out  1  registered SR.T
wbFault  out  1  sticky fault flag
clrBusy  out  1  high while clearing; core must stall FPU issue
retireCnt  out  32  count of committed FPU results, wraps

Behaviour:
- Reset (reset==0 at edge):
  - E2 valid=0, outSrT=0, wbFault=0, retireCnt=0.
  - State=CLEAR with clear pointer 0 and clrBusy=1; if CLEAR_ON_RESET=0, State=RUN and clrBusy=0.
  - Reset asserted mid-clear or mid-operation restarts from this state; the pending E2 entry is discarded.
- CLEAR state:
  - One array entry is written to 0 per cycle, pointer 0..NUM_FPR-1.
  - Goes to RUN on the edge that writes entry NUM_FPR-1, i.e. NUM_FPR cycles.
  - exHold does not pause the clear. All ex* inputs are ignored. Reads return 0.
- RUN state: "accept" = exOutOK==OK && !exFlush && !exHold && State==RUN.
  - On accept with a writable id: E2 <= {id, val}, E2 valid=1.
  - On accept with id=ZZR or id >= NUM_FPR: E2 valid=0, retireCnt still increments.
  - Any other condition with !exHold: E2 valid <= 0.
  - exHold=1: E2 holds unchanged and no array write occurs.
- Commit: at an edge with !exHold and E2 valid, array[E2.id] <= E2.val and retireCnt += 1.
  - Latency: EX result at cycle N is in E2 after edge N+1 and in the array after edge N+2.
  - During a hold, latency stretches by the hold length.
- SR.T: outSrT <= exOutSrT on accept. It is unchanged otherwise, including when exOutOK is HOLD or READY.
- Fault: exOutOK==FAULT && !exFlush && State==RUN sets wbFault=1. It clears only on reset. Nothing is latched into E2.
- Read forwarding, per port, highest priority first:
  1. id==ZZR or id >= NUM_FPR -> 0.
  2. EX bypass: exOutOK==OK, !exFlush, exOutId==id -> exOutVal. This is independent of exHold.
  3. E2 valid && E2.id==id -> E2.val.
  4. Otherwise array[id].
- Simultaneous events:
  - E2 commit to X while EX carries X: a read of X returns the EX value. The next accept overwrites E2, so the array gets the newer value one edge later.
  - Same id on all three ports: all three return the same value.
- retireCnt wraps from 0xFFFFFFFF to 0.

Decomposition:
- Shared package (FPU defines file): UMEM_OK_* codes, FPR_ZZR=6'h3F, clear/run state encoding.
- One natural sub-module, fpu_reg_array: one synchronous write port and three combinational read ports. It contains no forwarding logic.
- All bypass, E2 pipeline latch, FSM and counter logic live in fpu_reg_wb.

Test Plan:
- Reset low 1 cycle, NUM_FPR=64 -> clrBusy=1 for exactly 64 cycles. Then any read of ids 0..62 returns 0, and retireCnt=0.
- After clear: EX id=5 val=0x3FF0000000000000 OK=1, then the next two cycles READY.
  - rdIdRs=5 returns that value in cycles N, N+1 and N+2 (EX, E2 and array respectively); retireCnt=1.
- Back-to-back writes of id 7 with 0x1 then 0x2, rdIdRt=7 -> 0x1 in cycle N and 0x2 from N+1 onward. Array holds 0x2 after edge N+3.
- exHold=1 for 4 cycles with E2 holding id 9 -> no commit and retireCnt unchanged. The read of 9 returns the E2 value throughout. The commit happens on the first edge after exHold drops.
- EX OK with exFlush=1 for id 3 val 0xDEAD -> no bypass and no E2 load. The read of 3 stays 0.
  - EX FAULT -> wbFault=1 and stays 1 until reset.
- EX OK id=ZZR exOutSrT=1 -> outSrT=1 next cycle, retireCnt increments, a read of ZZR returns 0, no array write.

Source files
------------

// File: rtl/fpu_reg_wb_pkg.sv
// Shared FPU writeback definitions: status codes, zero-register id, state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_reg_wb_pkg;

  // Execute-unit status codes carried on exOutOK
  localparam logic [1:0] UMEM_OK_READY = 2'd0;
  localparam logic [1:0] UMEM_OK_OK    = 2'd1;
  localparam logic [1:0] UMEM_OK_HOLD  = 2'd2;
  localparam logic [1:0] UMEM_OK_FAULT = 2'd3;

  // Hard-wired zero register: never written, always reads 0
  localparam logic [5:0] FPR_ZZR = 6'h3F;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } wb_state_t;

  // E2 pipeline latch payload
  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] val;
  } e2_t;

endpackage

// File: rtl/fpu_reg_array.sv
// FPR storage: one synchronous write port, three combinational read ports, no forwarding.
// Latency: write visible on reads after the writing edge; reads are combinational.
// Backpressure: none; caller gates the write enable.
//
// Ports: clock; i_we/i_wid/i_wdat write port; i_rid_a/b/c read ids; o_rdat_a/b/c read data.
module fpu_reg_array #(
  parameter int NUM_FPR = 64
) (
  input  logic        clock,
  input  logic        i_we,
  input  logic [5:0]  i_wid,
  input  logic [63:0] i_wdat,
  input  logic [5:0]  i_rid_a,
  input  logic [5:0]  i_rid_b,
  input  logic [5:0]  i_rid_c,
  output logic [63:0] o_rdat_a,
  output logic [63:0] o_rdat_b,
  output logic [63:0] o_rdat_c
);

  // No reset: contents are initialised by the owner's clear walk.
  logic [63:0] r_mem [NUM_FPR];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_wid] <= i_wdat;
    end
  end

  assign o_rdat_a = r_mem[i_rid_a];
  assign o_rdat_b = r_mem[i_rid_b];
  assign o_rdat_c = r_mem[i_rid_c];

endmodule

// File: rtl/fpu_reg_wb.sv
// FPU writeback/bypass: E2 latch, FPR commit, 3-port forwarding, post-reset clear, SR.T, fault, retire count.
// Latency: EX result in E2 one edge later, in the array two edges later; reads are combinational.
// Backpressure: exHold freezes E2 and commit (not the clear walk); clrBusy asks the core to stall issue.
//
// Ports: clock, reset (sync active-low); exOut* execute result; exHold/exFlush pipeline control;
//        rdId*/rdVal* forwarded read ports; outSrT, wbFault, clrBusy, retireCnt status.
module fpu_reg_wb
  import fpu_reg_wb_pkg::*;
#(
  parameter int NUM_FPR        = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  exOutId,
  input  logic [63:0] exOutVal,
  input  logic [1:0]  exOutOK,
  input  logic        exOutSrT,
  input  logic        exHold,
  input  logic        exFlush,
  input  logic [5:0]  rdIdRs,
  input  logic [5:0]  rdIdRt,
  input  logic [5:0]  rdIdRn,
  output logic [63:0] rdValRs,
  output logic [63:0] rdValRt,
  output logic [63:0] rdValRn,
  output logic        outSrT,
  output logic        wbFault,
  output logic        clrBusy,
  output logic [31:0] retireCnt
);

  localparam logic [6:0] NUM_LIM = 7'(NUM_FPR);
  localparam logic [5:0] LAST_ID = 6'(NUM_FPR - 1);

  wb_state_t   r_state;
  logic [5:0]  r_clr_ptr;
  logic        r_clr_busy;
  logic        r_e2_vld;
  e2_t         r_e2;
  logic        r_srt;
  logic        r_fault;
  logic [31:0] r_retire;

  logic        w_ex_ok;
  logic        w_accept;
  logic        w_commit;
  logic        w_fault;
  logic        w_we;
  logic [5:0]  w_wid;
  logic [63:0] w_wdat;
  logic [63:0] w_arr_rs;
  logic [63:0] w_arr_rt;
  logic [63:0] w_arr_rn;
  logic [31:0] w_inc;

  // Ids that map onto real storage; ZZR and out-of-range ids are sinks.
  function automatic logic id_writable(input logic [5:0] id);
    return (id != FPR_ZZR) && ({1'b0, id} < NUM_LIM);
  endfunction

  // Bypass qualification deliberately ignores exHold so a stalled EX result still forwards.
  assign w_ex_ok  = (exOutOK == UMEM_OK_OK) && !exFlush && (r_state == ST_RUN);
  assign w_accept = w_ex_ok && !exHold;
  assign w_commit = r_e2_vld && !exHold;
  assign w_fault  = (exOutOK == UMEM_OK_FAULT) && !exFlush && (r_state == ST_RUN);

  // A sunk result retires at accept time; a real one retires when it commits.
  // Both can land on the same edge.
  assign w_inc = 32'(w_commit) + 32'(w_accept && !id_writable(exOutId));

  // Clear walk owns the write port; E2 is never valid while clearing.
  assign w_we   = (r_state == ST_CLEAR) || w_commit;
  assign w_wid  = (r_state == ST_CLEAR) ? r_clr_ptr : r_e2.id;
  assign w_wdat = (r_state == ST_CLEAR) ? 64'd0 : r_e2.val;

  fpu_reg_array #(
    .NUM_FPR (NUM_FPR)
  ) u_array (
    .clock    (clock),
    .i_we     (w_we),
    .i_wid    (w_wid),
    .i_wdat   (w_wdat),
    .i_rid_a  (rdIdRs),
    .i_rid_b  (rdIdRt),
    .i_rid_c  (rdIdRn),
    .o_rdat_a (w_arr_rs),
    .o_rdat_b (w_arr_rt),
    .o_rdat_c (w_arr_rn)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (CLEAR_ON_RESET) begin
        r_state    <= ST_CLEAR;
        r_clr_busy <= 1'b1;
      end else begin
        r_state    <= ST_RUN;
        r_clr_busy <= 1'b0;
      end
      r_clr_ptr <= '0;
      r_e2_vld  <= 1'b0;
      r_e2      <= '0;
      r_srt     <= 1'b0;
      r_fault   <= 1'b0;
      r_retire  <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 6'd1;
          if (r_clr_ptr == LAST_ID) begin
            r_state    <= ST_RUN;
            r_clr_busy <= 1'b0;
          end
        end
        default: begin
          if (!exHold) begin
            r_e2_vld <= w_accept && id_writable(exOutId);
            if (w_accept) begin
              r_e2.id  <= exOutId;
              r_e2.val <= exOutVal;
            end
          end
          if (w_accept) begin
            r_srt <= exOutSrT;
          end
          if (w_fault) begin
            r_fault <= 1'b1;
          end
          r_retire <= r_retire + w_inc;
        end
      endcase
    end
  end

  // Forwarding priority: sink id, EX bypass, E2 latch, array.
  function automatic logic [63:0] fwd(input logic [5:0] id, input logic [63:0] arr);
    if (!id_writable(id) || (r_state == ST_CLEAR)) begin
      return 64'd0;
    end else if (w_ex_ok && (exOutId == id)) begin
      return exOutVal;
    end else if (r_e2_vld && (r_e2.id == id)) begin
      return r_e2.val;
    end else begin
      return arr;
    end
  endfunction

  always_comb begin
    rdValRs = fwd(rdIdRs, w_arr_rs);
    rdValRt = fwd(rdIdRt, w_arr_rt);
    rdValRn = fwd(rdIdRn, w_arr_rn);
  end

  assign outSrT    = r_srt;
  assign wbFault   = r_fault;
  assign clrBusy   = r_clr_busy;
  assign retireCnt = r_retire;

endmodule

// File: tb/tb_fpu_reg_wb.sv
module tb_fpu_reg_wb;
  import fpu_reg_wb_pkg::*;

  logic        clock;
  logic        reset;
  logic [5:0]  exOutId;
  logic [63:0] exOutVal;
  logic [1:0]  exOutOK;
  logic        exOutSrT;
  logic        exHold;
  logic        exFlush;
  logic [5:0]  rdIdRs, rdIdRt, rdIdRn;
  logic [63:0] rdValRs, rdValRt, rdValRn;
  logic        outSrT;
  logic        wbFault;
  logic        clrBusy;
  logic [31:0] retireCnt;

  int n_cmp = 0;
  int n_err = 0;

  fpu_reg_wb #(.NUM_FPR(64), .CLEAR_ON_RESET(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .exOutId   (exOutId),
    .exOutVal  (exOutVal),
    .exOutOK   (exOutOK),
    .exOutSrT  (exOutSrT),
    .exHold    (exHold),
    .exFlush   (exFlush),
    .rdIdRs    (rdIdRs),
    .rdIdRt    (rdIdRt),
    .rdIdRn    (rdIdRn),
    .rdValRs   (rdValRs),
    .rdValRt   (rdValRt),
    .rdValRn   (rdValRn),
    .outSrT    (outSrT),
    .wbFault   (wbFault),
    .clrBusy   (clrBusy),
    .retireCnt (retireCnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  id;
    logic [63:0] val;
    logic [1:0]  ok;
    logic        srt;
    logic        hold;
    logic        flush;
    logic [5:0]  rs, rt, rn;
    logic [63:0] ers, ert, ern;   // reads in this cycle
    logic [31:0] ecnt;            // registered state after the edge
    logic        esrt;
    logic        efault;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] id, input logic [63:0] val, input logic [1:0] ok,
                     input logic srt, input logic hold, input logic flush,
                     input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rn,
                     input logic [63:0] ers, input logic [63:0] ert, input logic [63:0] ern,
                     input logic [31:0] ecnt, input logic esrt, input logic efault);
    vec_t v;
    v.id = id; v.val = val; v.ok = ok; v.srt = srt; v.hold = hold; v.flush = flush;
    v.rs = rs; v.rt = rt; v.rn = rn; v.ers = ers; v.ert = ert; v.ern = ern;
    v.ecnt = ecnt; v.esrt = esrt; v.efault = efault;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    exOutId = 6'd0; exOutVal = 64'd0; exOutOK = UMEM_OK_READY; exOutSrT = 1'b0;
    exHold = 1'b0; exFlush = 1'b0; rdIdRs = 6'd0; rdIdRt = 6'd0; rdIdRn = 6'd0;
  endtask

  // Hold reset low across exactly one rising edge, then check the reset state.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    idle();
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk({tag, " clrBusy"}, 64'(clrBusy), 64'd1);
    chk({tag, " retireCnt"}, 64'(retireCnt), 64'd0);
    chk({tag, " outSrT"}, 64'(outSrT), 64'd0);
    chk({tag, " wbFault"}, 64'(wbFault), 64'd0);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (clrBusy && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  localparam logic [63:0] V1 = 64'h3FF0000000000000;
  localparam logic [1:0]  OK = UMEM_OK_OK;
  localparam logic [1:0]  RD = UMEM_OK_READY;
  localparam logic [1:0]  HD = UMEM_OK_HOLD;
  localparam logic [1:0]  FT = UMEM_OK_FAULT;
  localparam logic [5:0]  Z  = FPR_ZZR;

  initial begin
    int n;
    reset = 1'b1;
    idle();

    // Fill the vector table: id val ok srt hold flush | rs rt rn | ers ert ern | cnt srt fault
    // Single write to id 5: EX bypass, then E2, then array
    add(5, V1, OK, 0, 0, 0,   5, 0, 62,   V1, 0, 0,   0, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   5, 0, 62,   V1, 0, 0,   1, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   5, 0, 62,   V1, 0, 0,   1, 0, 0);
    // Back-to-back id 7; EX beats E2 on the second
    add(7, 1,  OK, 0, 0, 0,   0, 7, 0,    0, 1, 0,    1, 0, 0);
    add(7, 2,  OK, 0, 0, 0,   0, 7, 0,    0, 2, 0,    2, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   0, 7, 0,    0, 2, 0,    3, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   7, 7, 7,    2, 2, 2,    3, 0, 0);
    // E2 holds id 9 through a 4-cycle stall; stalled EX still bypasses but is not taken
    add(9, 64'h99, OK, 0, 0, 0, 9, 10, 0, 64'h99, 0, 0,       3, 0, 0);
    add(10, 64'hAA, OK, 1, 1, 0, 9, 10, 0, 64'h99, 64'hAA, 0, 3, 0, 0);
    add(0, 0,  RD, 0, 1, 0,   9, 10, 0,   64'h99, 0, 0,       3, 0, 0);
    add(0, 0,  RD, 0, 1, 0,   9, 10, 0,   64'h99, 0, 0,       3, 0, 0);
    add(0, 0,  RD, 0, 1, 0,   9, 10, 0,   64'h99, 0, 0,       3, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   9, 10, 0,   64'h99, 0, 0,       4, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   9, 10, 0,   64'h99, 0, 0,       4, 0, 0);
    // Flushed result is neither forwarded nor latched
    add(3, 64'hDEAD, OK, 0, 0, 1, 3, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0,  RD, 0, 0, 0,   3, 0, 0,    0, 0, 0,    4, 0, 0);
    // Fault: sticky, no forward, no retire
    add(4, 64'h44, FT, 0, 0, 0, 4, 0, 0,  0, 0, 0,    4, 0, 1);
    add(0, 0,  RD, 0, 0, 0,   4, 0, 0,    0, 0, 0,    4, 0, 1);
    // ZZR write: SR.T taken, retires, reads stay 0
    add(Z, 64'h77, OK, 1, 0, 0, Z, 0, 0,  0, 0, 0,    5, 1, 1);
    add(0, 0,  RD, 0, 0, 0,   Z, 62, 63,  0, 0, 0,    5, 1, 1);
    add(0, 0,  HD, 0, 0, 0,   Z, 0, 0,    0, 0, 0,    5, 1, 1);
    // Commit of id 12 on the same edge as a ZZR accept retires two
    add(12, 64'hC, OK, 0, 0, 0, 12, 0, 0, 64'hC, 0, 0, 5, 0, 1);
    add(Z, 0,  OK, 1, 0, 0,   12, Z, 0,   64'hC, 0, 0, 7, 1, 1);
    add(0, 0,  RD, 0, 0, 0,   12, 0, 0,   64'hC, 0, 0, 7, 1, 1);

    // Reset, then re-reset in the middle of the clear walk; EX input ignored while clearing
    do_reset("rst0");
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      exOutOK = OK; exOutId = 6'd1; exOutVal = 64'h5; rdIdRs = 6'd1;
      #1;
      if (c == 5) chk("clear read", rdValRs, 64'd0);
    end
    do_reset("rst1");
    wait_clear(n);
    chk("clear cycles", 64'(n), 64'd64);
    @(negedge clock);
    rdIdRs = 6'd1; rdIdRt = 6'd31; rdIdRn = 6'd62;
    #1;
    chk("post-clear rs", rdValRs, 64'd0);
    chk("post-clear rt", rdValRt, 64'd0);
    chk("post-clear rn", rdValRn, 64'd0);
    chk("post-clear cnt", 64'(retireCnt), 64'd0);

    foreach (tbl[i]) begin
      @(negedge clock);
      exOutId = tbl[i].id; exOutVal = tbl[i].val; exOutOK = tbl[i].ok;
      exOutSrT = tbl[i].srt; exHold = tbl[i].hold; exFlush = tbl[i].flush;
      rdIdRs = tbl[i].rs; rdIdRt = tbl[i].rt; rdIdRn = tbl[i].rn;
      #1;
      chk($sformatf("v%0d rdValRs", i), rdValRs, tbl[i].ers);
      chk($sformatf("v%0d rdValRt", i), rdValRt, tbl[i].ert);
      chk($sformatf("v%0d rdValRn", i), rdValRn, tbl[i].ern);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d retireCnt", i), 64'(retireCnt), 64'(tbl[i].ecnt));
      chk($sformatf("v%0d outSrT", i), 64'(outSrT), 64'(tbl[i].esrt));
      chk($sformatf("v%0d wbFault", i), 64'(wbFault), 64'(tbl[i].efault));
    end

    // Reset with a pending E2 entry: entry discarded, array cleared again
    @(negedge clock);
    idle();
    exOutOK = OK; exOutId = 6'd20; exOutVal = 64'h55;
    @(posedge clock);
    #1;
    do_reset("rst2");
    wait_clear(n);
    chk("clear cycles 2", 64'(n), 64'd64);
    @(negedge clock);
    rdIdRs = 6'd20; rdIdRt = 6'd12; rdIdRn = 6'd9;
    #1;
    chk("rst2 rd20", rdValRs, 64'd0);
    chk("rst2 rd12", rdValRt, 64'd0);
    chk("rst2 rd9", rdValRn, 64'd0);
    @(posedge clock);
    #1;
    chk("rst2 cnt", 64'(retireCnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
